// File: rtl/count_pwm_compare.sv
// count_pwm_compare: turns a live up/down counter value into a complementary
// PWM pair with dead-time insertion. The duty value is double-buffered and
// the pending value is only applied at a period boundary (count reaching 0),
// so no PWM period is ever cut short or stretched by a mid-period write.
module count_pwm_compare #(
    parameter int WIDTH = 8,
    parameter int DEAD  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             duty_wr,
    input  logic [WIDTH-1:0] duty_in,
    output logic             pwm_h,
    output logic             pwm_l,
    output logic             period_tick,
    output logic             duty_pending
);

    // Dead-time reload value; a 4-bit counter covers the legal 1..15 range.
    localparam logic [3:0] DT_LOAD = 4'(DEAD - 1);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    logic [WIDTH-1:0] count_q_r;
    logic [WIDTH-1:0] duty_act_r;
    logic [WIDTH-1:0] shadow_r;
    logic             side_r;
    logic [3:0]       dt_cnt_r;

    logic             bnd_s;
    logic             raw_s;
    logic [WIDTH-1:0] duty_act_nxt_s;
    logic [WIDTH-1:0] shadow_nxt_s;
    logic             pending_nxt_s;
    logic             side_nxt_s;
    logic [3:0]       dt_cnt_nxt_s;
    logic             pwm_h_nxt_s;
    logic             pwm_l_nxt_s;

    // A boundary is the arrival at zero; a counter parked at zero flags only once.
    assign bnd_s = (count == ZERO_W) && (count_q_r != ZERO_W);

    // Compare uses the active duty as it stood before this edge.
    assign raw_s = (count < duty_act_r);

    // Double-buffer next state: pending shadow goes active on a boundary,
    // a same-cycle write refills the shadow and keeps the pending flag set.
    always_comb begin
        duty_act_nxt_s = duty_act_r;
        shadow_nxt_s   = shadow_r;
        pending_nxt_s  = duty_pending;
        if (bnd_s && duty_pending) begin
            duty_act_nxt_s = shadow_r;
            pending_nxt_s  = 1'b0;
        end else begin
            duty_act_nxt_s = duty_act_r;
        end
        if (duty_wr) begin
            shadow_nxt_s  = duty_in;
            pending_nxt_s = 1'b1;
        end else begin
            shadow_nxt_s = shadow_r;
        end
    end

    // Dead-time next state: any side change (or disable) reloads the dead
    // time with both outputs low; outputs follow the side only once it expires.
    always_comb begin
        side_nxt_s   = side_r;
        dt_cnt_nxt_s = dt_cnt_r;
        pwm_h_nxt_s  = 1'b0;
        pwm_l_nxt_s  = 1'b0;
        if (!en) begin
            side_nxt_s   = raw_s;
            dt_cnt_nxt_s = DT_LOAD;
        end else if (raw_s != side_r) begin
            side_nxt_s   = raw_s;
            dt_cnt_nxt_s = DT_LOAD;
        end else if (dt_cnt_r != 4'd0) begin
            dt_cnt_nxt_s = dt_cnt_r - 4'd1;
        end else begin
            pwm_h_nxt_s = side_r;
            pwm_l_nxt_s = ~side_r;
        end
    end

    // State and registered outputs; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q_r    <= ZERO_W;
            duty_act_r   <= ZERO_W;
            shadow_r     <= ZERO_W;
            duty_pending <= 1'b0;
            side_r       <= 1'b0;
            dt_cnt_r     <= DT_LOAD;
            pwm_h        <= 1'b0;
            pwm_l        <= 1'b0;
            period_tick  <= 1'b0;
        end else begin
            count_q_r    <= count;
            duty_act_r   <= duty_act_nxt_s;
            shadow_r     <= shadow_nxt_s;
            duty_pending <= pending_nxt_s;
            side_r       <= side_nxt_s;
            dt_cnt_r     <= dt_cnt_nxt_s;
            pwm_h        <= pwm_h_nxt_s;
            pwm_l        <= pwm_l_nxt_s;
            period_tick  <= bnd_s;
        end
    end

endmodule

// File: tb/tb_count_pwm_compare.sv
// Directed bench for count_pwm_compare (WIDTH=8, DEAD=2). Inputs change 1 time
// unit after each rising edge; outputs are read at that same point, so they
// reflect the edge just taken.
module tb_count_pwm_compare;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       duty_wr;
    logic [7:0] count;
    logic [7:0] duty_in;
    logic       pwm_h;
    logic       pwm_l;
    logic       period_tick;
    logic       duty_pending;

    int checks = 0;
    int errors = 0;
    int ov_cnt = 0;

    count_pwm_compare #(.WIDTH(8), .DEAD(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .count        (count),
        .en           (en),
        .duty_wr      (duty_wr),
        .duty_in      (duty_in),
        .pwm_h        (pwm_h),
        .pwm_l        (pwm_l),
        .period_tick  (period_tick),
        .duty_pending (duty_pending)
    );

    // 10-unit clock.
    always #5 clk = ~clk;

    // Track any cycle where both gate drives are on.
    always @(negedge clk) begin
        if (pwm_h === 1'b1 && pwm_l === 1'b1) ov_cnt <= ov_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive count from first to last (either direction), one value per edge,
    // and tally what the outputs did.
    task automatic sweep(input int first, input int last,
                         output int nh, output int nl, output int nlow,
                         output int ntick, output int first_h);
        int n;
        int dir;
        int c;
        nh = 0; nl = 0; nlow = 0; ntick = 0; first_h = -1;
        dir = (last >= first) ? 1 : -1;
        n   = (last >= first) ? (last - first + 1) : (first - last + 1);
        for (int i = 0; i < n; i++) begin
            c = first + i * dir;
            count = c[7:0];
            step();
            if (pwm_h === 1'b1) nh++;
            if (pwm_l === 1'b1) nl++;
            if (pwm_h === 1'b0 && pwm_l === 1'b0) nlow++;
            if (period_tick === 1'b1) ntick++;
            if (pwm_h === 1'b1 && first_h < 0) first_h = c;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; en = 1'b1; count = 8'd0; duty_wr = 1'b0; duty_in = 8'd0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (pwm_h !== 1'b0 || pwm_l !== 1'b0 || period_tick !== 1'b0 || duty_pending !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold h=%b l=%b tick=%b pend=%b required all 0", pwm_h, pwm_l, period_tick, duty_pending);
            end
        end
        rst = 1'b0;
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL release_edge1 h=%b l=%b required h=0 l=0", pwm_h, pwm_l);
        end
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b1) begin
            errors++;
            $display("FAIL release_edge2 h=%b l=%b required h=0 l=1", pwm_h, pwm_l);
        end
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (period_tick !== 1'b0 || pwm_l !== 1'b1 || pwm_h !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_hold bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_up_sweep();
        int nh, nl, nlow, ntick, fh;
        count = 8'd0; duty_wr = 1'b1; duty_in = 8'd64;
        step();
        duty_wr = 1'b0;
        checks++;
        if (duty_pending !== 1'b1) begin
            errors++;
            $display("FAIL up_pending_set got=%b required 1", duty_pending);
        end
        sweep(1, 255, nh, nl, nlow, ntick, fh);
        count = 8'd0;
        step();
        checks++;
        if (period_tick !== 1'b1 || duty_pending !== 1'b0) begin
            errors++;
            $display("FAIL up_wrap_apply tick=%b pend=%b required tick=1 pend=0", period_tick, duty_pending);
        end
        sweep(1, 255, nh, nl, nlow, ntick, fh);
        sweep(0, 255, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 62 || nl != 190 || nlow != 4) begin
            errors++;
            $display("FAIL up_duty64 h=%0d l=%0d low=%0d required 62 190 4", nh, nl, nlow);
        end
        checks++;
        if (ntick != 1) begin
            errors++;
            $display("FAIL up_tick_count got=%0d required 1", ntick);
        end
    endtask

    task automatic test_down_sweep();
        int nh, nl, nlow, ntick, fh;
        count = 8'd254; duty_wr = 1'b1; duty_in = 8'd128;
        step();
        duty_wr = 1'b0;
        sweep(253, 0, nh, nl, nlow, ntick, fh);
        checks++;
        if (ntick != 1 || duty_pending !== 1'b0) begin
            errors++;
            $display("FAIL down_apply ticks=%0d pend=%b required 1 0", ntick, duty_pending);
        end
        sweep(255, 0, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 126 || nl != 126 || nlow != 4) begin
            errors++;
            $display("FAIL down_duty128 h=%0d l=%0d low=%0d required 126 126 4", nh, nl, nlow);
        end
        checks++;
        if (fh != 125) begin
            errors++;
            $display("FAIL down_first_h got_count=%0d required 125", fh);
        end
        checks++;
        if (ntick != 1 || period_tick !== 1'b1) begin
            errors++;
            $display("FAIL down_tick ticks=%0d last=%b required 1 1", ntick, period_tick);
        end
    endtask

    task automatic test_write_on_boundary();
        int nh, nl, nlow, ntick, fh;
        sweep(1, 49, nh, nl, nlow, ntick, fh);
        count = 8'd50; duty_wr = 1'b1; duty_in = 8'd32;
        step();
        duty_wr = 1'b0;
        sweep(51, 255, nh, nl, nlow, ntick, fh);
        count = 8'd0; duty_wr = 1'b1; duty_in = 8'd200;
        step();
        duty_wr = 1'b0;
        checks++;
        if (period_tick !== 1'b1 || duty_pending !== 1'b1) begin
            errors++;
            $display("FAIL bnd_write tick=%b pend=%b required tick=1 pend=1", period_tick, duty_pending);
        end
        sweep(1, 255, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 30) begin
            errors++;
            $display("FAIL duty32_applied h=%0d required 30", nh);
        end
        count = 8'd0;
        step();
        checks++;
        if (period_tick !== 1'b1 || duty_pending !== 1'b0) begin
            errors++;
            $display("FAIL second_bnd tick=%b pend=%b required tick=1 pend=0", period_tick, duty_pending);
        end
        sweep(1, 255, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 198) begin
            errors++;
            $display("FAIL duty200_applied h=%0d required 198", nh);
        end
    endtask

    task automatic test_enable_runt();
        int nh, nl, nlow, ntick, fh;
        int bad;
        count = 8'd0;
        step();
        sweep(1, 100, nh, nl, nlow, ntick, fh);
        checks++;
        if (pwm_h !== 1'b1) begin
            errors++;
            $display("FAIL high_phase h=%b required 1", pwm_h);
        end
        en = 1'b0;
        bad = 0;
        for (int c = 101; c <= 103; c++) begin
            count = 8'(c);
            step();
            if (pwm_h !== 1'b0 || pwm_l !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL en_low_outputs bad_cycles=%0d required 0", bad);
        end
        en = 1'b1;
        count = 8'd104;
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL reenable_dead h=%b l=%b required 0 0", pwm_h, pwm_l);
        end
        count = 8'd105;
        step();
        checks++;
        if (pwm_h !== 1'b1 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL reenable_high h=%b l=%b required 1 0", pwm_h, pwm_l);
        end
        count = 8'd106; duty_wr = 1'b1; duty_in = 8'd1;
        step();
        duty_wr = 1'b0;
        sweep(107, 255, nh, nl, nlow, ntick, fh);
        count = 8'd0;
        step();
        sweep(1, 255, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 0) begin
            errors++;
            $display("FAIL runt_transition h=%0d required 0", nh);
        end
        sweep(0, 255, nh, nl, nlow, ntick, fh);
        checks++;
        if (nh != 0 || nl != 253 || nlow != 3) begin
            errors++;
            $display("FAIL runt_duty1 h=%0d l=%0d low=%0d required 0 253 3", nh, nl, nlow);
        end
    endtask

    task automatic test_reset_mid_dead();
        int bad;
        count = 8'd0;
        step();
        checks++;
        if (period_tick !== 1'b1 || pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL flip_edge tick=%b h=%b l=%b required 1 0 0", period_tick, pwm_h, pwm_l);
        end
        rst = 1'b1; count = 8'd1; duty_wr = 1'b1; duty_in = 8'd77;
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0 || period_tick !== 1'b0 || duty_pending !== 1'b0) begin
            errors++;
            $display("FAIL mid_dead_reset h=%b l=%b tick=%b pend=%b required all 0", pwm_h, pwm_l, period_tick, duty_pending);
        end
        rst = 1'b0; duty_wr = 1'b0; count = 8'd0;
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL recover_edge1 h=%b l=%b required 0 0", pwm_h, pwm_l);
        end
        step();
        checks++;
        if (pwm_h !== 1'b0 || pwm_l !== 1'b1) begin
            errors++;
            $display("FAIL recover_edge2 h=%b l=%b required 0 1", pwm_h, pwm_l);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (pwm_h !== 1'b0 || pwm_l !== 1'b1 || period_tick !== 1'b0 || duty_pending !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL recover_duty_zero bad_cycles=%0d required 0", bad);
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (ov_cnt != 0) begin
            errors++;
            $display("FAIL overlap cycles=%0d required 0", ov_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; count = 8'd0; duty_wr = 1'b0; duty_in = 8'd0;
        test_reset();
        test_up_sweep();
        test_down_sweep();
        test_write_on_boundary();
        test_enable_runt();
        test_reset_mid_dead();
        test_no_overlap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
